// File: rtl/clock_divider_multi_pkg.sv
// clkdiv_pkg: shared constants and types for the multi-channel clock divider.
package clkdiv_pkg;
  localparam int MIN_DIV = 2;
  localparam int DEFAULT_DIV_P = 20;
  localparam int DEF_CNT_W = 16;
  typedef logic [DEF_CNT_W-1:0] div_t;
  typedef enum logic {CH_IDLE, CH_RUN} ch_state_e;
endpackage

// File: rtl/clock_divider_multi_if.sv
// clock_divider_multi_if: control and output bundle of the multi-channel clock divider.
interface clock_divider_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 16
);
  logic [NUM_CH*CNT_W-1:0] div_val;
  logic [NUM_CH-1:0] div_load;
  logic [NUM_CH-1:0] ch_en;
  logic sync_restart;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] load_pend;
  modport master (
    output div_val, div_load, ch_en, sync_restart,
    input clk_out, tick, load_pend
  );
  modport slave (
    input div_val, div_load, ch_en, sync_restart,
    output clk_out, tick, load_pend
  );
endinterface

// File: rtl/clock_divider_multi_channel.sv
// clk_div_channel: one divider channel with shadowed divisor, run/idle FSM and registered outputs.
module clk_div_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DEFAULT_DIV = DEFAULT_DIV_P
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  input  logic             ch_en,
  input  logic             sync_restart,
  output logic             clk_out,
  output logic             tick,
  output logic             load_pend
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN = CNT_W'(MIN_DIV);
  ch_state_e state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, active, active_n, shadow, shadow_n;
  logic pend_n, clk_n, tick_n, run, wrap, start;
  always_comb begin
    run = state == CH_RUN;
    wrap = run && cnt == active - CNT_W'(1);
    start = ch_en && (!run || sync_restart);
    state_n = ch_en ? CH_RUN : CH_IDLE;
    shadow_n = div_load ? (div_val < MIN ? MIN : div_val) : shadow;
    active_n = active;
    pend_n = load_pend;
    // a load coinciding with a period boundary takes effect at that boundary
    if (start || wrap) begin
      active_n = shadow_n;
      pend_n = 1'b0;
    end else if (div_load) begin
      pend_n = 1'b1;
    end else if (!run && load_pend) begin
      active_n = shadow;
      pend_n = 1'b0;
    end
    cnt_n = (!ch_en || start || wrap) ? '0 : cnt + CNT_W'(1);
    clk_n = ch_en && cnt_n < (active_n >> 1);
    tick_n = ch_en && cnt_n == '0;
  end
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= CH_IDLE;
      cnt <= '0;
      active <= DEF;
      shadow <= DEF;
      load_pend <= 1'b0;
      clk_out <= 1'b0;
      tick <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      active <= active_n;
      shadow <= shadow_n;
      load_pend <= pend_n;
      clk_out <= clk_n;
      tick <= tick_n;
    end
  end
endmodule

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CH independent runtime-programmable clock dividers with tick strobes.
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 16,
  parameter int DEFAULT_DIV = DEFAULT_DIV_P
) (
  input logic clk_in,
  input logic rst_n,
  clock_divider_multi_if.slave bus
);
  logic [NUM_CH-1:0] clk_o, tick_o, pend_o;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .CNT_W(CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_in(clk_in),
      .rst_n(rst_n),
      .div_val(bus.div_val[i*CNT_W +: CNT_W]),
      .div_load(bus.div_load[i]),
      .ch_en(bus.ch_en[i]),
      .sync_restart(bus.sync_restart),
      .clk_out(clk_o[i]),
      .tick(tick_o[i]),
      .load_pend(pend_o[i])
    );
  end
  assign bus.clk_out = clk_o;
  assign bus.tick = tick_o;
  assign bus.load_pend = pend_o;
endmodule
